// File: rtl/debug_unit_ctrl.sv
// debug_unit_ctrl: MIPS debug unit controller.
// Decodes UART command bytes, assembles program bytes into 32-bit instruction
// memory writes, and sequences the CPU in continuous-run or single-step mode.
// Optional build macro: DEBUG_UNIT_CTRL_ECHO_EN enables the UART echo path;
// without it o_tx_start/o_tx_data are tied low.
module debug_unit_ctrl #(
    parameter int unsigned MEM_INST_SIZE = 64,
    parameter logic [31:0] HALT_WORD     = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_done,
    input  logic        i_cpu_halt,
    output logic        o_imem_we,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_data,
    output logic        o_cpu_en,
    output logic        o_cpu_rst,
    output logic        o_load_done,
    output logic [2:0]  o_state,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StRun  = 3'd2,
        StStep = 3'd3,
        StDone = 3'd4
    } state_e;

    localparam logic [7:0]  CmdLoad  = 8'h4C;
    localparam logic [7:0]  CmdRun   = 8'h52;
    localparam logic [7:0]  CmdStep  = 8'h53;
    localparam logic [7:0]  CmdNext  = 8'h4E;
    // Byte address of the last instruction word; a write here ends the load.
    localparam logic [31:0] LastAddr = 32'(4 * (MEM_INST_SIZE - 1));

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    // Only the first three bytes need storing; the fourth comes straight off i_rx_data.
    logic [23:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic        imem_we_q, imem_we_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_data_q, imem_data_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        load_done_q, load_done_d;
    logic        step_pulse_q, step_pulse_d;

    logic [31:0] full_word;
    logic        cmd_state;
    logic        cmd_load;
    logic        word_wr;
    logic        load_end;
    logic        step_fire;

    // Decode byte-level events from the current state and the received byte.
    always_comb begin
        full_word = {word_q, i_rx_data};
        cmd_state = (state_q == StIdle) || (state_q == StDone);
        cmd_load  = i_rx_done && cmd_state && (i_rx_data == CmdLoad);
        word_wr   = i_rx_done && (state_q == StLoad) && (byte_cnt_q == 2'd3);
        load_end  = word_wr && ((full_word == HALT_WORD) || (addr_q == LastAddr));
        // Halt has priority over a coincident 'N'.
        step_fire = i_rx_done && (state_q == StStep) && (i_rx_data == CmdNext) && !i_cpu_halt;
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_rx_done) begin
                    if (i_rx_data == CmdLoad) begin
                        state_d = StLoad;
                    end else if (i_rx_data == CmdRun) begin
                        state_d = StRun;
                    end else if (i_rx_data == CmdStep) begin
                        state_d = StStep;
                    end
                end
            end
            StLoad: begin
                if (load_end) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (i_cpu_halt) begin
                    state_d = StDone;
                end
            end
            StStep: begin
                if (i_cpu_halt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Only a reload leaves DONE.
                if (cmd_load) begin
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Load datapath and single-cycle pulse generation.
    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        addr_d       = addr_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_data_d  = imem_data_q;
        cpu_rst_d    = 1'b0;
        load_done_d  = 1'b0;
        step_pulse_d = step_fire;

        if (cmd_load) begin
            byte_cnt_d = 2'd0;
            word_d     = 24'd0;
            addr_d     = 32'd0;
            cpu_rst_d  = 1'b1;
        end else if (i_rx_done && (state_q == StLoad)) begin
            word_d     = full_word[23:0];
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (word_wr) begin
                imem_we_d   = 1'b1;
                imem_addr_d = addr_q;
                imem_data_d = full_word;
                load_done_d = load_end;
                // Hold at the last word so the address never wraps.
                if (addr_q != LastAddr) begin
                    addr_d = addr_q + 32'd4;
                end
            end
        end
    end

    // Datapath and pulse registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            byte_cnt_q   <= 2'd0;
            word_q       <= 24'd0;
            addr_q       <= 32'd0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= 32'd0;
            imem_data_q  <= 32'd0;
            cpu_rst_q    <= 1'b0;
            load_done_q  <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_data_q  <= imem_data_d;
            cpu_rst_q    <= cpu_rst_d;
            load_done_q  <= load_done_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    // FSM outputs.
    always_comb begin
        o_state     = state_q;
        o_cpu_en    = (state_q == StRun) || step_pulse_q;
        o_cpu_rst   = cpu_rst_q;
        o_load_done = load_done_q;
        o_imem_we   = imem_we_q;
        o_imem_addr = imem_addr_q;
        o_imem_data = imem_data_q;
    end

`ifdef DEBUG_UNIT_CTRL_ECHO_EN
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;

    // Echo command bytes, and the low byte of each written word.
    always_comb begin
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        if (i_rx_done && (cmd_state || (state_q == StStep))) begin
            tx_start_d = 1'b1;
            tx_data_d  = i_rx_data;
        end else if (word_wr) begin
            tx_start_d = 1'b1;
            tx_data_d  = full_word[7:0];
        end
    end

    // Echo registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
        end else begin
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
`else
    assign o_tx_start = 1'b0;
    assign o_tx_data  = 8'd0;
`endif

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Bench for debug_unit_ctrl: directed steps, instruction-memory writes checked
// against a scoreboard queue filled when the program bytes are driven.
module tb_debug_unit_ctrl;

    localparam int unsigned MEM_INST_SIZE = 64;

    logic        i_clk;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic        i_cpu_halt;
    logic        o_imem_we;
    logic [31:0] o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_cpu_en;
    logic        o_cpu_rst;
    logic        o_load_done;
    logic [2:0]  o_state;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int en_cnt = 0;
    int rst_cnt = 0;
    int ld_cnt = 0;
    int tx_cnt = 0;
    logic [63:0] exp_q[$];

    debug_unit_ctrl #(
        .MEM_INST_SIZE(MEM_INST_SIZE),
        .HALT_WORD    (32'hFFFF_FFFF)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rx_data  (i_rx_data),
        .i_rx_done  (i_rx_done),
        .i_cpu_halt (i_cpu_halt),
        .o_imem_we  (o_imem_we),
        .o_imem_addr(o_imem_addr),
        .o_imem_data(o_imem_data),
        .o_cpu_en   (o_cpu_en),
        .o_cpu_rst  (o_cpu_rst),
        .o_load_done(o_load_done),
        .o_state    (o_state),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one byte; returns #1 after the edge that sampled it.
    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(posedge i_clk);
        #1;
        i_rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr);
        exp_q.push_back({addr, w});
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    // Scoreboard pop on each write, plus pulse counters.
    always @(negedge i_clk) begin
        if (o_imem_we) begin
            wr_cnt++;
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("imem_addr", 64'(o_imem_addr), 64'(e[63:32]));
                chk("imem_data", 64'(o_imem_data), 64'(e[31:0]));
            end
        end
        if (o_cpu_en)    en_cnt++;
        if (o_cpu_rst)   rst_cnt++;
        if (o_load_done) ld_cnt++;
        if (o_tx_start)  tx_cnt++;
    end

    initial begin
        int snap_en;
        int snap_wr;
        int snap_ld;
        int snap_rst;

        i_reset    = 1'b1;
        i_rx_data  = 8'd0;
        i_rx_done  = 1'b0;
        i_cpu_halt = 1'b0;
        idle(3);
        i_reset = 1'b0;
        idle(1);

        // Reset state
        chk("rst_state", 64'(o_state), 64'd0);
        chk("rst_outputs", {o_imem_we, o_cpu_en, o_cpu_rst, o_load_done, o_tx_start, o_tx_data},
            64'd0);
        chk("rst_addr_data", {o_imem_addr, o_imem_data}, 64'd0);

        // Load with halt terminator
        snap_ld = ld_cnt;
        send_byte(8'h4C);
        chk("load_state", 64'(o_state), 64'd1);
        chk("load_cpu_rst", 64'(o_cpu_rst), 64'd1);
        send_word(32'h0022_0820, 32'd0);
        chk("load_rst_one_cycle", 64'(rst_cnt), 64'd1);
        send_word(32'hFFFF_FFFF, 32'd4);
        chk("halt_we_now", 64'(o_imem_we), 64'd1);
        chk("halt_done_now", 64'(o_load_done), 64'd1);
        chk("halt_state_idle", 64'(o_state), 64'd0);
        idle(2);
        chk("halt_load_done_once", 64'(ld_cnt - snap_ld), 64'd1);
        chk("halt_writes", 64'(wr_cnt), 64'd2);

        // Full-memory load auto-ends at the last word
        send_byte(8'h4C);
        for (int i = 0; i < int'(MEM_INST_SIZE); i++) begin
            send_word({8'hA0, 8'(i), 16'h0001}, 32'(4 * i));
            if (i == 0) chk("full_state_load", 64'(o_state), 64'd1);
        end
        chk("full_last_addr", 64'(o_imem_addr), 64'(4 * (MEM_INST_SIZE - 1)));
        chk("full_state_idle", 64'(o_state), 64'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        idle(2);
        chk("full_no_wrap_write", 64'(wr_cnt), 64'(2 + MEM_INST_SIZE));
        chk("full_queue_empty", 64'(exp_q.size()), 64'd0);

        // Continuous run, halt after 10 enabled cycles
        snap_en = en_cnt;
        send_byte(8'h52);
        chk("run_state", 64'(o_state), 64'd2);
        chk("run_en", 64'(o_cpu_en), 64'd1);
        idle(9);
        i_cpu_halt = 1'b1;
        idle(1);
        chk("run_done_state", 64'(o_state), 64'd4);
        chk("run_en_dropped", 64'(o_cpu_en), 64'd0);
        i_cpu_halt = 1'b0;
        send_byte(8'h52);
        idle(3);
        chk("done_ignores_r", 64'(o_state), 64'd4);
        chk("run_en_cycles", 64'(en_cnt - snap_en), 64'd10);
        send_byte(8'h53);
        chk("done_ignores_s", 64'(o_state), 64'd4);

        // Back to IDLE through a one-word halt load
        snap_rst = rst_cnt;
        send_byte(8'h4C);
        chk("done_accepts_l", 64'(o_state), 64'd1);
        send_word(32'hFFFF_FFFF, 32'd0);
        chk("reload_idle", 64'(o_state), 64'd0);
        chk("reload_rst_pulse", 64'(rst_cnt - snap_rst), 64'd1);

        // Single step
        snap_en = en_cnt;
        send_byte(8'h53);
        chk("step_state", 64'(o_state), 64'd3);
`ifdef DEBUG_UNIT_CTRL_ECHO_EN
        chk("echo_start", 64'(o_tx_start), 64'd1);
        chk("echo_data", 64'(o_tx_data), 64'h53);
`else
        chk("no_echo_start", 64'(o_tx_start), 64'd0);
`endif
        chk("step_idle_en", 64'(o_cpu_en), 64'd0);
        send_byte(8'h4E);
        chk("step_pulse_on", 64'(o_cpu_en), 64'd1);
        idle(1);
        chk("step_pulse_off", 64'(o_cpu_en), 64'd0);
        send_byte(8'h41);
        send_byte(8'h4E);
        send_byte(8'h4E);
        idle(2);
        i_cpu_halt = 1'b1;
        send_byte(8'h4E);
        chk("step_halt_state", 64'(o_state), 64'd4);
        chk("step_halt_no_en", 64'(o_cpu_en), 64'd0);
        i_cpu_halt = 1'b0;
        idle(2);
        chk("step_en_cycles", 64'(en_cnt - snap_en), 64'd3);

        // Reset mid-load discards the partial word
        snap_wr = wr_cnt;
        send_byte(8'h4C);
        send_byte(8'hDE);
        send_byte(8'hAD);
        i_reset = 1'b1;
        idle(2);
        i_reset = 1'b0;
        idle(1);
        chk("midrst_state", 64'(o_state), 64'd0);
        chk("midrst_no_write", 64'(wr_cnt - snap_wr), 64'd0);
        send_byte(8'h4C);
        send_word(32'h1234_5678, 32'd0);
        chk("midrst_state_load", 64'(o_state), 64'd1);
        idle(2);
        chk("midrst_one_write", 64'(wr_cnt - snap_wr), 64'd1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
`ifndef DEBUG_UNIT_CTRL_ECHO_EN
        chk("no_echo_ever", 64'(tx_cnt), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
